// File: rtl/mc_front_end_pkg.sv
// mc_front_end_pkg: shared widths, request type encoding and request record for the controller front end
package mc_front_end_pkg;
  localparam logic READ = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam int RA_POS = 10;
  localparam int CA = 10;
  localparam int RA = 16;
  localparam int DQ = 16;
  localparam int IDX = 7;
  localparam int WR_FIFO_SIZE = 2;
  localparam int WR_FIFO_NUM = 3;
  localparam int WR_MAX = WR_FIFO_SIZE * WR_FIFO_NUM;
  localparam int NB = 16;
  localparam int AW = RA_POS + RA + 4;
  typedef enum logic {write = WRITE, read = READ} r_type;
  typedef struct packed {
    r_type req_type;
    logic [DQ-1:0] data;
    logic [AW-1:0] address;
  } request_t;
endpackage

// File: rtl/mc_front_end_if.sv
// mc_front_end_if: host request, back-end completion and per-bank dispatch signals of the front end
interface mc_front_end_if;
  import mc_front_end_pkg::*;
  logic in_valid;
  r_type in_request_type;
  logic [DQ-1:0] in_request_data;
  logic [AW-1:0] in_request_address;
  logic out_busy;
  logic request_done_valid;
  r_type the_type;
  logic [DQ-1:0] data_in;
  logic [IDX-1:0] index;
  logic write_done;
  logic read_done;
  logic [DQ-1:0] data_out;
  logic [NB-1:0] ready;
  logic [NB-1:0] valid_o;
  logic [NB-1:0] t_o;
  logic [NB-1:0][DQ-1:0] dq_o;
  logic [NB-1:0][IDX-1:0] idx_o;
  logic [NB-1:0][RA-1:0] ra_o;
  logic [NB-1:0][CA-1:0] ca_o;
  modport master (
    output in_valid, in_request_type, in_request_data, in_request_address,
    output request_done_valid, the_type, data_in, index, ready,
    input out_busy, write_done, read_done, data_out, valid_o, t_o, dq_o, idx_o, ra_o, ca_o
  );
  modport slave (
    input in_valid, in_request_type, in_request_data, in_request_address,
    input request_done_valid, the_type, data_in, index, ready,
    output out_busy, write_done, read_done, data_out, valid_o, t_o, dq_o, idx_o, ra_o, ca_o
  );
endinterface

// File: rtl/mc_front_end_reorder_table.sv
// mc_reorder_table: tag allocation, completion capture and strictly in-order retirement
module mc_reorder_table
  import mc_front_end_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic alloc,
  input  r_type alloc_type,
  input  logic cmp_valid,
  input  logic [IDX-1:0] cmp_index,
  input  logic [DQ-1:0] cmp_data,
  output logic [IDX-1:0] tail,
  output logic full,
  output logic ret_write,
  output logic read_done,
  output logic write_done,
  output logic [DQ-1:0] data_out
);
  localparam int DEPTH = 1 << IDX;
  logic [IDX:0] head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0] pend_q, pend_d, done_q, done_d, type_q, type_d;
  logic [DQ-1:0] data_q [DEPTH];
  logic [DQ-1:0] data_d [DEPTH];
  logic read_done_q, read_done_d, write_done_q, write_done_d, ret, take_cmp;
  logic [DQ-1:0] data_out_q, data_out_d;
  logic [IDX-1:0] h;
  always_comb begin
    h = head_q[IDX-1:0];
    tail = tail_q[IDX-1:0];
    ret = done_q[h];
    ret_write = ret && type_q[h] == WRITE;
    full = tail_q - head_q == (IDX+1)'(DEPTH);
    take_cmp = cmp_valid && pend_q[cmp_index] && !done_q[cmp_index];
    pend_d = pend_q;
    done_d = done_q;
    type_d = type_q;
    data_d = data_q;
    if (ret) begin
      pend_d[h] = 1'b0;
      done_d[h] = 1'b0;
    end
    if (alloc) begin
      pend_d[tail] = 1'b1;
      type_d[tail] = alloc_type;
    end
    if (take_cmp) done_d[cmp_index] = 1'b1;
    if (take_cmp && type_q[cmp_index] == READ) data_d[cmp_index] = cmp_data;
    head_d = head_q + (IDX+1)'(ret);
    tail_d = tail_q + (IDX+1)'(alloc);
    read_done_d = ret && type_q[h] == READ;
    write_done_d = ret_write;
    data_out_d = read_done_d ? data_q[h] : '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      pend_q <= '0;
      done_q <= '0;
      type_q <= '0;
      read_done_q <= 1'b0;
      write_done_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      pend_q <= pend_d;
      done_q <= done_d;
      type_q <= type_d;
      read_done_q <= read_done_d;
      write_done_q <= write_done_d;
      data_out_q <= data_out_d;
    end
  always_ff @(posedge clk) data_q <= data_d;
  assign read_done = read_done_q;
  assign write_done = write_done_q;
  assign data_out = data_out_q;
endmodule

// File: rtl/mc_front_end.sv
// mc_front_end: DRAM controller request front end with per-bank dispatch and in-order completion return
module mc_front_end
  import mc_front_end_pkg::*;
(
  input logic clk,
  input logic rst,
  mc_front_end_if.slave bus
);
  localparam int WR_W = $clog2(WR_MAX + 1);
  logic stg_valid_q, stg_valid_d;
  request_t stg_q, stg_d;
  logic [IDX-1:0] stg_idx_q, stg_idx_d, tail;
  logic [WR_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [3:0] bank;
  logic xfer, busy, accept, acc_write, tbl_full, ret_write;
  mc_reorder_table u_tbl (
    .clk(clk),
    .rst(rst),
    .alloc(accept),
    .alloc_type(bus.in_request_type),
    .cmp_valid(bus.request_done_valid),
    .cmp_index(bus.index),
    .cmp_data(bus.data_in),
    .tail(tail),
    .full(tbl_full),
    .ret_write(ret_write),
    .read_done(bus.read_done),
    .write_done(bus.write_done),
    .data_out(bus.data_out)
  );
  always_comb begin
    bank = stg_q.address[AW-1 -: 4];
    xfer = stg_valid_q && bus.ready[bank];
    busy = (stg_valid_q && !xfer) || tbl_full || wr_cnt_q == WR_W'(WR_MAX);
    accept = bus.in_valid && !busy;
    acc_write = accept && bus.in_request_type == write;
    stg_valid_d = accept || (stg_valid_q && !xfer);
    stg_d = accept ? request_t'{req_type: bus.in_request_type, data: bus.in_request_data,
                               address: bus.in_request_address} : stg_q;
    stg_idx_d = accept ? tail : stg_idx_q;
    wr_cnt_d = wr_cnt_q + WR_W'(acc_write) - WR_W'(ret_write);
    bus.out_busy = busy;
    for (int i = 0; i < NB; i++) begin
      bus.valid_o[i] = stg_valid_q && bank == 4'(i);
      bus.t_o[i] = bus.valid_o[i] && stg_q.req_type == read;
      bus.dq_o[i] = bus.valid_o[i] ? stg_q.data : '0;
      bus.idx_o[i] = bus.valid_o[i] ? stg_idx_q : '0;
      bus.ra_o[i] = bus.valid_o[i] ? stg_q.address[RA_POS +: RA] : '0;
      bus.ca_o[i] = bus.valid_o[i] ? stg_q.address[CA-1:0] : '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stg_valid_q <= 1'b0;
      stg_q <= '0;
      stg_idx_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      stg_valid_q <= stg_valid_d;
      stg_q <= stg_d;
      stg_idx_q <= stg_idx_d;
      wr_cnt_q <= wr_cnt_d;
    end
endmodule

// File: tb/tb_mc_front_end.sv
// tb_mc_front_end: scoreboard bench for dispatch, in-order retirement, backpressure and limits
module tb_mc_front_end;
  import mc_front_end_pkg::*;
  typedef struct {logic rd; logic [DQ-1:0] d;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mc_front_end_if bus ();
  mc_front_end dut (.clk(clk), .rst(rst), .bus(bus.slave));
  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0;
  int fails = 0;
  logic [IDX-1:0] next_tag;
  logic ttype [128];
  logic [DQ-1:0] rplan [128];
  logic [IDX-1:0] tags [6];
  logic [IDX-1:0] tmp;
  logic rd_r;
  int j;
  int order [6] = '{1, 2, 4, 5, 6, 3};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk)
    if (!rst && (bus.read_done || bus.write_done)) begin
      if (exp_q.size() == 0) chk("retire_extra", 64'({bus.read_done, bus.write_done}), 64'(0));
      else begin
        mon_e = exp_q.pop_front();
        chk("retire_type", 64'({bus.read_done, bus.write_done}), 64'({mon_e.rd, !mon_e.rd}));
        if (mon_e.rd) chk("retire_data", 64'(bus.data_out), 64'(mon_e.d));
      end
    end

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.request_done_valid = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(bus.out_busy), 64'(0));
    chk("rst_valid_o", 64'(bus.valid_o), 64'(0));
    chk("rst_dones", 64'({bus.read_done, bus.write_done}), 64'(0));
    chk("rst_data_out", 64'(bus.data_out), 64'(0));
    exp_q.delete();
    next_tag = '0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue(input logic rd, input logic [DQ-1:0] d, input logic [AW-1:0] a,
                       input logic [DQ-1:0] rexp);
    int n = 0;
    logic [3:0] b;
    logic [3:0] ob;
    logic [IDX-1:0] t;
    b = a[AW-1 -: 4];
    ob = b + 4'd1;
    bus.in_valid = 1'b1;
    bus.in_request_type = r_type'(rd);
    bus.in_request_data = d;
    bus.in_request_address = a;
    @(negedge clk);
    while (bus.out_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.out_busy) begin
      chk("accept_timeout", 64'(bus.out_busy), 64'(0));
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    t = next_tag;
    next_tag++;
    ttype[t] = rd;
    rplan[t] = rexp;
    exp_q.push_back('{rd, rexp});
    @(negedge clk);
    chk("disp_valid", 64'(bus.valid_o), 64'(16'h1 << b));
    chk("disp_idx", 64'(bus.idx_o[b]), 64'(t));
    chk("disp_ra", 64'(bus.ra_o[b]), 64'(a[RA_POS +: RA]));
    chk("disp_ca", 64'(bus.ca_o[b]), 64'(a[CA-1:0]));
    chk("disp_t", 64'(bus.t_o[b]), 64'(rd));
    chk("disp_dq", 64'(bus.dq_o[b]), 64'(d));
    chk("disp_other", 64'({bus.dq_o[ob], bus.ra_o[ob], bus.ca_o[ob], bus.idx_o[ob], bus.t_o[ob]}), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic complete(input logic [IDX-1:0] t, input logic [DQ-1:0] d, input logic ty);
    bus.request_done_valid = 1'b1;
    bus.index = t;
    bus.data_in = d;
    bus.the_type = r_type'(ty);
    @(posedge clk);
    #1 bus.request_done_valid = 1'b0;
  endtask

  task automatic drain(input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    #1 chk("drain_left", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_request_type = write;
    bus.in_request_data = '0;
    bus.in_request_address = '0;
    bus.request_done_valid = 1'b0;
    bus.the_type = write;
    bus.data_in = '0;
    bus.index = '0;
    bus.ready = '1;
    #2 do_reset();
    bus.ready = 16'h0008;
    issue(1'b1, 16'h0, {4'd3, 16'd5, 10'd7}, 16'hA5A5);
    complete(7'd0, 16'hA5A5, 1'b1);
    drain(20);
    bus.ready = '1;
    do_reset();
    complete(7'd1, 16'hDEAD, 1'b1);
    issue(1'b1, 16'h0, {4'd1, 16'd100, 10'd1}, 16'h1234);
    issue(1'b1, 16'h0, {4'd2, 16'd200, 10'd2}, 16'hBEEF);
    complete(7'd1, 16'hBEEF, 1'b1);
    complete(7'd1, 16'hFFFF, 1'b1);
    complete(7'd0, 16'h1234, 1'b0);
    @(negedge clk);
    chk("ooo_latency", 64'(bus.read_done), 64'(0));
    @(negedge clk);
    chk("ooo_first", 64'(bus.read_done), 64'(1));
    drain(20);
    issue(1'b0, 16'h5555, {4'd9, 16'd9, 10'd9}, 16'h0);
    do_reset();
    bus.ready = '0;
    issue(1'b1, 16'h0, {4'd2, 16'd7, 10'd3}, 16'h0102);
    repeat (3) begin
      @(negedge clk);
      chk("bp_busy", 64'(bus.out_busy), 64'(1));
      chk("bp_hold", 64'(bus.valid_o), 64'(16'h0004));
    end
    bus.ready = 16'h0004;
    #1 chk("bp_release", 64'(bus.out_busy), 64'(0));
    @(posedge clk);
    #1 issue(1'b0, 16'hCAFE, {4'd2, 16'd8, 10'd4}, 16'h0);
    complete(7'd1, 16'h0, 1'b0);
    complete(7'd0, 16'h0102, 1'b1);
    drain(20);
    bus.ready = '1;
    do_reset();
    for (int i = 0; i < 6; i++) issue(1'b0, 16'(i * 3 + 1), {4'(i), 16'(i), 10'(i)}, 16'h0);
    @(negedge clk);
    chk("wl_busy", 64'(bus.out_busy), 64'(1));
    @(posedge clk);
    #1 complete(7'd0, 16'h0, 1'b0);
    @(negedge clk);
    chk("wl_busy_hold", 64'(bus.out_busy), 64'(1));
    @(negedge clk);
    chk("wl_wdone", 64'(bus.write_done), 64'(1));
    chk("wl_busy_drop", 64'(bus.out_busy), 64'(0));
    @(posedge clk);
    #1 issue(1'b0, 16'h7777, {4'd15, 16'hFFFF, 10'h3FF}, 16'h0);
    for (int i = 0; i < 6; i++) complete(7'(order[i]), 16'h0, 1'b0);
    drain(40);
    do_reset();
    for (int i = 0; i < 128; i++) issue(1'b1, 16'(i), {4'(i), 16'(i * 5), 10'(i)}, 16'(i * 7 + 3));
    @(negedge clk);
    chk("full_busy", 64'(bus.out_busy), 64'(1));
    @(posedge clk);
    #1 complete(7'd0, rplan[0], 1'b1);
    @(negedge clk);
    chk("full_busy_hold", 64'(bus.out_busy), 64'(1));
    @(negedge clk);
    chk("full_busy_drop", 64'(bus.out_busy), 64'(0));
    @(posedge clk);
    #1;
    for (int i = 127; i >= 1; i--) complete(7'(i), rplan[i], 1'b1);
    drain(400);
    for (int bt = 0; bt < 25; bt++) begin
      for (int i = 0; i < 6; i++) begin
        tags[i] = next_tag;
        rd_r = 1'($urandom);
        issue(rd_r, 16'($urandom), AW'($urandom), 16'($urandom));
      end
      for (int i = 5; i > 0; i--) begin
        j = $urandom_range(i, 0);
        tmp = tags[i];
        tags[i] = tags[j];
        tags[j] = tmp;
      end
      for (int i = 0; i < 6; i++) complete(tags[i], rplan[tags[i]], 1'($urandom));
    end
    drain(100);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
